// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with a single registered output stage.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise lowest index wins.
module stream_mux_nto1 #(
    parameter  int DATA_W   = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    input  logic [CHANNELS-1:0]          valid_in,
    output logic [CHANNELS-1:0]          ready_out,
    input  logic                         force_en_in,
    input  logic [SEL_W-1:0]             force_sel_in,
    output logic [DATA_W-1:0]            y_out,
    output logic                         y_valid_out,
    input  logic                         y_ready_in,
    output logic [SEL_W-1:0]             y_chan_out
);

    logic                load;
    logic [CHANNELS-1:0] elig;
    logic                found;
    logic [SEL_W-1:0]    grant;
    logic [DATA_W-1:0]   grant_data;

    logic [DATA_W-1:0]   y_q, y_d;
    logic [SEL_W-1:0]    chan_q, chan_d;
    logic                valid_q, valid_d;

    assign load = !valid_q || y_ready_in;

    // Force mode narrows eligibility to one channel; an out-of-range index matches none.
    always_comb begin
        elig = '0;
        if (force_en_in) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (force_sel_in == SEL_W'(i)) begin
                    elig[i] = valid_in[i];
                end
            end
        end else begin
            elig = valid_in;
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Search begins one past the last granted channel and wraps.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!found && elig[i] && ((32'(ptr_q) + off) % CHANNELS == i)) begin
                    found = 1'b1;
                    grant = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found && load) begin
            ptr_d = grant;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q <= SEL_W'(CHANNELS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                grant = SEL_W'(i);
            end
        end
    end
`endif

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ready_out = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            ready_out[i] = found && load && rst_n_in && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        y_d     = y_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                y_d    = grant_data;
                chan_d = grant;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            y_q     <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign y_out       = y_q;
    assign y_chan_out  = chan_q;
    assign y_valid_out = valid_q;

endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Parametrised N-to-1 streaming multiplexer with valid/ready handshake on every channel and a registered output stage. It is the successor to the combinational 2:1 mux: it generalises data width and channel count, and arbitrates between competing inputs. An optional explicit select path overrides arbitration. It sits between multiple producer blocks and a single shared consumer.

## Interface
- DATA_W, 4, data width per channel
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, derived localparam = $clog2(CHANNELS), not overridable
- clk_in  input  1  clock; all logic on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- data_in  input  CHANNELS*DATA_W  packed channel data; channel k at [k*DATA_W +: DATA_W]
- valid_in  input  CHANNELS  per-channel valid
- ready_out  output  CHANNELS  per-channel ready; at most one bit high
- force_en_in  input  1  explicit select mode enable
- force_sel_in  input  SEL_W  channel index used when force_en_in=1
- y_out  output  DATA_W  registered output data
- y_valid_out  output  1  output valid
- y_ready_in  input  1  consumer ready
- y_chan_out  output  SEL_W  index of channel that supplied y_out

Clock is clk_in; reset is asynchronous, active-low, rst_n_in.

## Operation
- Output stage is one register: y_out, y_chan_out, y_valid_out.
- load = !y_valid_out || y_ready_in. The stage accepts new data only when load=1.
- Eligible set:
  - force_en_in=0: all channels with valid_in=1.
  - force_en_in=1: only channel force_sel_in, if its valid_in=1.
  - force_sel_in ≥ CHANNELS: nothing is eligible.
- Grant g is chosen combinationally from the eligible set. Default policy is fixed priority: the lowest index wins.
- ready_out[g] = load && rst_n_in. All other ready_out bits are 0. If nothing is eligible, ready_out is all 0.
- An input transfer occurs when valid_in[g] && ready_out[g]. On that edge:
  - y_out ← channel g data
  - y_chan_out ← g
  - y_valid_out ← 1
- If load=1 and there is no transfer, y_valid_out ← 0. y_out and y_chan_out hold their last values.
- While y_valid_out=1 and y_ready_in=0, y_out and y_chan_out are stable and ready_out is all 0.
- Producers must hold valid_in and data until accepted. The block never drops or duplicates a word.

## Timing
- Reset values: y_out=0, y_chan_out=0, y_valid_out=0, ready_out=0 (forced 0 combinationally while rst_n_in=0). The round-robin pointer resets to CHANNELS-1.
- Latency: 1 cycle from input transfer to y_valid_out=1.
- Throughput: 1 word per cycle when y_ready_in is held at 1.
- ready_out has a combinational dependency on y_ready_in, valid_in, force_en_in and force_sel_in. There is no combinational path from any input to y_out or y_valid_out.
- force_en_in and force_sel_in are sampled every cycle. A change takes effect on the next grant and never alters a word already in the output stage.
- Output pop and input push in the same cycle: the new word replaces the old one, with no bubble.
- Reset asserted mid-operation: the output stage clears immediately and the word it held is discarded. The first grant after reset follows normal rules.

## Configuration
- Macro: STREAM_MUX_RR_EN.
- Defined: round-robin arbitration when force_en_in=0.
  - Search starts at pointer+1 and wraps modulo CHANNELS.
  - The pointer ← g only on an accepted input transfer.
  - force_en_in=1 transfers also update the pointer.
- Undefined: fixed lowest-index priority. The pointer register is not instantiated.
- Force mode behaves identically in both builds.

## Test plan
All scenarios use DATA_W=4, CHANNELS=4.
- Reset: assert rst_n_in=0 with valid_in=4'b1111 → ready_out=0000, y_valid_out=0, y_out=0, y_chan_out=0 throughout. Release → first grant goes to channel 0.
- Priority (macro off): valid_in=0110, ch1=4'hA, ch2=4'h5, y_ready_in=1 → next cycle y_out=A, y_chan_out=1. With ch1 held valid, ch2 is never granted. Drop ch1 → y_out=5, y_chan_out=2.
- Backpressure: y_valid_out=1, y_out=4'h3; hold y_ready_in=0 for 3 cycles → y_out=3 stable, ready_out=0000. Raise y_ready_in → the next pending word appears the following cycle, with no loss or duplicate.
- Force: force_en_in=1, force_sel_in=3, valid_in=1111, ch3=4'hC → only ready_out[3]=1, y_out=C, y_chan_out=3. Drop valid_in[3] → ready_out=0000, y_valid_out falls to 0 after the consumer pops.
- Round-robin (macro on): valid_in=1111 held, y_ready_in=1 → y_chan_out sequence 0,1,2,3,0,1. Add y_ready_in=0 for 2 cycles mid-sequence → the sequence resumes without skipping a channel.
- Pointer persistence (macro on): grant ch2, then valid_in=0101 → ch0 is granted next, then ch2.
